// File: rtl/mips_reg_file.sv
// -----------------------------------------------------------------------------
// mips_reg_file
//
// 32 x DATA_W general-purpose register file plus the HI/LO pair for a
// single-cycle MIPS datapath. Reads are combinational with write-through
// bypass, so a value written this cycle is visible on the read ports in the
// same cycle. r0 is hardwired to zero.
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous active-high reset
//   raddr_a    read port A address (rs)      -> rdata_a (ALU in1)
//   raddr_b    read port B address (rt)      -> rdata_b (ALU in2 / store data)
//   we         GPR write enable
//   waddr      GPR write address (rd/rt)
//   wdata      GPR write data (ALU out or load data)
//   hilo_we    HI/LO write enable (mult/div result), writes both together
//   hi_wdata   new HI value
//   lo_wdata   new LO value
//   hi_rdata   HI value (mfhi), bypassed
//   lo_rdata   LO value (mflo), bypassed
//   dbg_addr   debug read address
//   dbg_rdata  debug read data, stored value only (no bypass)
// -----------------------------------------------------------------------------
module mips_reg_file #(
  parameter int                DATA_W  = 32,
  parameter logic [DATA_W-1:0] SP_INIT = 32'h0000_3FFC,
  parameter logic [DATA_W-1:0] GP_INIT = 32'h0000_1800
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [4:0]        raddr_a,
  output logic [DATA_W-1:0] rdata_a,
  input  logic [4:0]        raddr_b,
  output logic [DATA_W-1:0] rdata_b,
  input  logic              we,
  input  logic [4:0]        waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              hilo_we,
  input  logic [DATA_W-1:0] hi_wdata,
  input  logic [DATA_W-1:0] lo_wdata,
  output logic [DATA_W-1:0] hi_rdata,
  output logic [DATA_W-1:0] lo_rdata,
  input  logic [4:0]        dbg_addr,
  output logic [DATA_W-1:0] dbg_rdata
);

  localparam logic [4:0] ZERO_REG = 5'd0;
  localparam logic [4:0] GP_REG   = 5'd28;
  localparam logic [4:0] SP_REG   = 5'd29;

  // Entry 0 exists only so every 5-bit address indexes in range; it is
  // cleared on reset, never written, and all read ports mask address 0.
  logic [DATA_W-1:0] regs [0:31];
  logic [DATA_W-1:0] hi_q;
  logic [DATA_W-1:0] lo_q;

  // A GPR write that will actually commit on the next edge. Reset drops the
  // write, and r0 writes are discarded, so neither may bypass either.
  logic gpr_wr_live;
  logic hilo_wr_live;

  assign gpr_wr_live  = we && !rst && (waddr != ZERO_REG);
  assign hilo_wr_live = hilo_we && !rst;

  // Reset image of one register: $gp and $sp start at their ABI values,
  // everything else at zero.
  function automatic logic [DATA_W-1:0] reset_value(input logic [4:0] idx);
    logic [DATA_W-1:0] val;
    val = '0;
    if (idx == GP_REG) val = GP_INIT;
    if (idx == SP_REG) val = SP_INIT;
    return val;
  endfunction

  // ---------------------------------------------------------------------------
  // GPR storage
  // ---------------------------------------------------------------------------
  // NOTE: every entry is reset explicitly, so no read can ever return X; this
  // keeps the array in flops rather than a RAM macro, which is intended here.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) begin
        // NOTE: sequential state uses non-blocking assignment so all flops
        // update together from pre-edge values, independent of block order.
        regs[i] <= reset_value(i[4:0]);
      end
    end else if (we && (waddr != ZERO_REG)) begin
      regs[waddr] <= wdata;
    end
  end

  // ---------------------------------------------------------------------------
  // HI/LO storage: always written as a pair
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      hi_q <= '0;
      lo_q <= '0;
    end else if (hilo_we) begin
      hi_q <= hi_wdata;
      lo_q <= lo_wdata;
    end
  end

  // ---------------------------------------------------------------------------
  // Read port A
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: assigning a default first makes every path drive the output, so
    // no latch is inferred from the address-0 and bypass branches.
    rdata_a = '0;
    if (raddr_a != ZERO_REG) begin
      if (gpr_wr_live && (waddr == raddr_a)) rdata_a = wdata;
      else                                   rdata_a = regs[raddr_a];
    end
  end

  // ---------------------------------------------------------------------------
  // Read port B (bypasses independently of port A)
  // ---------------------------------------------------------------------------
  always_comb begin
    rdata_b = '0;
    if (raddr_b != ZERO_REG) begin
      if (gpr_wr_live && (waddr == raddr_b)) rdata_b = wdata;
      else                                   rdata_b = regs[raddr_b];
    end
  end

  // ---------------------------------------------------------------------------
  // Debug port: stored value only, so a bench can see what has committed
  // ---------------------------------------------------------------------------
  always_comb begin
    dbg_rdata = '0;
    if (dbg_addr != ZERO_REG) dbg_rdata = regs[dbg_addr];
  end

  // ---------------------------------------------------------------------------
  // HI/LO read with bypass
  // ---------------------------------------------------------------------------
  always_comb begin
    hi_rdata = hi_q;
    lo_rdata = lo_q;
    if (hilo_wr_live) begin
      hi_rdata = hi_wdata;
      lo_rdata = lo_wdata;
    end
  end

endmodule

// File: doc/mips_reg_file.md
Name: mips_reg_file

Overview:
- 32 x 32-bit MIPS general-purpose register file, plus the HI/LO pair, for the single-cycle CPU.
- Sits directly upstream of the ALU: read port A drives ALU in1; read port B drives ALU in2, or the store data when in2 is an immediate.
- Writeback (ALU out, or load data) returns through the write port.
- Read is combinational with write-through bypass, so a single-cycle datapath sees a value in the same cycle it is written.

Parameters:
- DATA_W, 32, register width in bits.
- SP_INIT, 32'h0000_3FFC, reset value of $sp (r29).
- GP_INIT, 32'h0000_1800, reset value of $gp (r28).

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous active-high reset.
- raddr_a  in  5  read port A address (rs).
- rdata_a  out  DATA_W  read port A data.
- raddr_b  in  5  read port B address (rt).
- rdata_b  out  DATA_W  read port B data.
- we  in  1  GPR write enable.
- waddr  in  5  GPR write address (rd/rt).
- wdata  in  DATA_W  GPR write data.
- hilo_we  in  1  HI/LO write enable (mult/div result).
- hi_wdata  in  DATA_W  new HI value.
- lo_wdata  in  DATA_W  new LO value.
- hi_rdata  out  DATA_W  HI value (mfhi).
- lo_rdata  out  DATA_W  LO value (mflo).
- dbg_addr  in  5  debug/bench read address.
- dbg_rdata  out  DATA_W  debug read data (no bypass).

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high, sampled on the rising edge of clk.
- Reset (rst=1 at a rising edge):
  - All GPRs clear to 0, except r28=GP_INIT and r29=SP_INIT.
  - HI=0, LO=0.
  - Reset takes priority over we and hilo_we in the same cycle; that write is dropped.
- After reset, outputs settle combinationally:
  - rdata_a/rdata_b/dbg_rdata = 0 for any address other than 28/29.
  - hi_rdata = lo_rdata = 0.
- GPR write: on the rising edge with rst=0 and we=1, reg[waddr] <= wdata. Latency 1 edge.
- r0 is hardwired to 0:
  - Writes with waddr=0 are discarded.
  - Reads of address 0 return 0 on every port, including through bypass.
- GPR read, ports A and B:
  - Purely combinational, 0-cycle latency.
  - If we=1, rst=0, waddr!=0 and waddr==raddr_x, then rdata_x = wdata (bypass).
  - Otherwise rdata_x = reg[raddr_x].
  - Both ports may read the same address. Both bypass independently.
- HI/LO write: on the rising edge with rst=0 and hilo_we=1, HI <= hi_wdata and LO <= lo_wdata together. Neither register can be written alone.
- HI/LO read:
  - Combinational.
  - If hilo_we=1 and rst=0, hi_rdata = hi_wdata and lo_rdata = lo_wdata (bypass).
  - Otherwise the stored values.
- Simultaneous we and hilo_we: both writes commit on the same edge; the two are independent.
- Debug port: combinational read of reg[dbg_addr], no bypass; dbg_addr=0 returns 0.
- No X propagation:
  - All storage is reset.
  - Addresses are full 5-bit, so every index is valid and there is no out-of-range case.
- During rst=1 the outputs show the stored and bypassed values as defined above. rst does not force the outputs, and bypass is disabled while rst=1.

Test Plan:
- Reset values: assert rst for 2 cycles, then read r0, r5, r28, r29, HI, LO -> 0, 0, 32'h1800, 32'h3FFC, 0, 0.
- Write/read-back:
  - we=1, waddr=8, wdata=32'hDEAD_BEEF for one edge.
  - Next cycle raddr_a=8, raddr_b=8 -> both 32'hDEAD_BEEF.
  - dbg_addr=8 -> 32'hDEAD_BEEF.
- r0 protection: we=1, waddr=0, wdata=32'hFFFF_FFFF -> rdata_a with raddr_a=0 reads 0 both during the write cycle (no bypass) and after it.
- Same-cycle bypass:
  - r9 holds 32'h11.
  - Drive we=1, waddr=9, wdata=32'h22, raddr_a=9, raddr_b=10 (r10=32'h33).
  - Before the edge: rdata_a=32'h22, rdata_b=32'h33, dbg_rdata (dbg_addr=9)=32'h11.
  - After the edge: dbg_rdata=32'h22.
- HI/LO:
  - hilo_we=1, hi_wdata=32'h1, lo_wdata=32'hFFFF_FFFE -> hi_rdata/lo_rdata show the new values combinationally and hold them after the edge.
  - A simultaneous GPR write to r3=32'h5 also commits.
- Reset mid-operation:
  - rst=1 and we=1 (waddr=12, wdata=32'h77) on the same edge -> r12=0 afterwards.
  - r29 returns to 32'h3FFC even if previously written to 32'h100.
